// File: rtl/wbuf_pkg.sv
// Shared types and default sizes for the posted write buffer.
package wbuf_pkg;

    localparam int unsigned WBUF_DEPTH  = 4;
    localparam int unsigned WBUF_ADDR_W = 28;
    localparam int unsigned WBUF_DATA_W = 128;

    typedef enum logic [1:0] {
        C_IDLE,
        C_WAIT,
        C_ACK
    } cstate_t;

    typedef enum logic [1:0] {
        M_IDLE,
        M_WRITE,
        M_READ
    } mstate_t;

endpackage

// File: rtl/mem_write_buffer_if.sv
// Cache-side and memory-side bus of the write buffer, plus its status flags.
// slave: the buffer's view; master: the cache/memory environment's view.
interface mem_write_buffer_if
    import wbuf_pkg::*;
#(
    parameter int unsigned ADDR_W = WBUF_ADDR_W,
    parameter int unsigned DATA_W = WBUF_DATA_W
);
    logic              c_read;
    logic              c_write;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic [DATA_W-1:0] c_rdata;
    logic              c_ready;
    logic              m_read;
    logic              m_write;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              m_ready;
    logic              wb_empty;
    logic              wb_full;

    modport slave (
        input  c_read, c_write, c_addr, c_wdata, m_rdata, m_ready,
        output c_rdata, c_ready, m_read, m_write, m_addr, m_wdata, wb_empty, wb_full
    );

    modport master (
        output c_read, c_write, c_addr, c_wdata, m_rdata, m_ready,
        input  c_rdata, c_ready, m_read, m_write, m_addr, m_wdata, wb_empty, wb_full
    );
endinterface

// File: rtl/wbuf_fifo.sv
// Entry storage for the write buffer: circular FIFO with per-entry valid,
// address match against the incoming cache address, and newest-match select.
// A cache write either coalesces into a matching entry or pushes at the tail.
// Optional read forwarding match is built only when WBUF_FWD_EN is defined.
module wbuf_fifo
    import wbuf_pkg::*;
#(
    parameter int unsigned DEPTH  = WBUF_DEPTH,
    parameter int unsigned ADDR_W = WBUF_ADDR_W,
    parameter int unsigned DATA_W = WBUF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              head_busy,
    input  logic              pop,
`ifdef WBUF_FWD_EN
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
`endif
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic              empty,
    output logic              full,
    output logic              more
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;

    logic [PTR_W-1:0]  slot [DEPTH];
    logic              coal_hit;
    logic [PTR_W-1:0]  coal_idx;
    logic              push;

    // Slot indices in age order, oldest (head) first.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot[i] = head_q + PTR_W'(i);
        end
    end

    // Coalesce target: newest valid match, never the head while it is in flight.
    always_comb begin
        coal_hit = 1'b0;
        coal_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[slot[i]] && (addr_q[slot[i]] == addr) && !((i == 0) && head_busy)) begin
                coal_hit = 1'b1;
                coal_idx = slot[i];
            end
        end
    end

`ifdef WBUF_FWD_EN
    // Forward source: newest valid match, head included.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[slot[i]] && (addr_q[slot[i]] == addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[slot[i]];
            end
        end
    end
`endif

    assign push      = wr_en && !coal_hit;
    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign more      = (count_q > CNT_W'(1)) || push;
    assign head_addr = addr_q[head_q];
    assign head_data = data_q[head_q];

    // Storage, pointers and occupancy; push and pop may share a cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
            end
            if (push) begin
                addr_q[tail_q]  <= addr;
                data_q[tail_q]  <= wr_data;
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PTR_W'(1);
            end
            if (wr_en && coal_hit) begin
                data_q[coal_idx] <= wr_data;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/mem_write_buffer.sv
// Posted write buffer between a write-through L1 cache and main memory.
// Cache FSM acks writes after one cycle; memory FSM drains entries in order
// and serves reads once the buffer is empty. Defining WBUF_FWD_EN lets a read
// that hits a buffered entry be answered from the buffer in one cycle.
module mem_write_buffer
    import wbuf_pkg::*;
#(
    parameter int unsigned DEPTH  = WBUF_DEPTH,
    parameter int unsigned ADDR_W = WBUF_ADDR_W,
    parameter int unsigned DATA_W = WBUF_DATA_W
) (
    input logic                clk,
    input logic                proc_reset_n,
    mem_write_buffer_if.slave  bus
);
    cstate_t           cstate, c_next;
    mstate_t           mstate, m_next;
    logic              wr_en, pop, rd_req, rd_done, head_busy;
    logic              empty, full, more;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [DATA_W-1:0] c_rdata_q;
`ifdef WBUF_FWD_EN
    logic              fwd_hit, fwd_take;
    logic [DATA_W-1:0] fwd_data;
`endif

    assign head_busy = (mstate == M_WRITE);
    assign rd_req    = (cstate == C_WAIT) && empty && (mstate == M_IDLE);
    assign rd_done   = (cstate == C_WAIT) && (mstate == M_READ) && bus.m_ready;

    wbuf_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (proc_reset_n),
        .wr_en     (wr_en),
        .addr      (bus.c_addr),
        .wr_data   (bus.c_wdata),
        .head_busy (head_busy),
        .pop       (pop),
`ifdef WBUF_FWD_EN
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
`endif
        .head_addr (head_addr),
        .head_data (head_data),
        .empty     (empty),
        .full      (full),
        .more      (more)
    );

    // State registers for both FSMs.
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            cstate <= C_IDLE;
            mstate <= M_IDLE;
        end else begin
            cstate <= c_next;
            mstate <= m_next;
        end
    end

    // Cache FSM next state; a write takes priority over a simultaneous read.
    always_comb begin
        c_next = cstate;
        wr_en  = 1'b0;
`ifdef WBUF_FWD_EN
        fwd_take = 1'b0;
`endif
        unique case (cstate)
            C_IDLE: begin
                if (bus.c_write) begin
                    if (!full) begin
                        wr_en  = 1'b1;
                        c_next = C_ACK;
                    end
                end else if (bus.c_read) begin
`ifdef WBUF_FWD_EN
                    if (fwd_hit) begin
                        fwd_take = 1'b1;
                        c_next   = C_ACK;
                    end else begin
                        c_next = C_WAIT;
                    end
`else
                    c_next = C_WAIT;
`endif
                end
            end
            C_WAIT:  if (rd_done) c_next = C_ACK;
            C_ACK:   c_next = C_IDLE;
            default: c_next = C_IDLE;
        endcase
    end

    // Memory FSM next state; a drain always runs to completion before a read.
    always_comb begin
        m_next = mstate;
        pop    = 1'b0;
        unique case (mstate)
            M_IDLE: begin
                if (!empty)      m_next = M_WRITE;
                else if (rd_req) m_next = M_READ;
            end
            M_WRITE: begin
                if (bus.m_ready) begin
                    pop    = 1'b1;
                    m_next = more ? M_WRITE : M_IDLE;
                end
            end
            M_READ:  if (bus.m_ready) m_next = M_IDLE;
            default: m_next = M_IDLE;
        endcase
    end

    // Read data captured from memory (or the buffer) for the ack cycle.
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            c_rdata_q <= '0;
        end else if (rd_done) begin
            c_rdata_q <= bus.m_rdata;
`ifdef WBUF_FWD_EN
        end else if (fwd_take) begin
            c_rdata_q <= fwd_data;
`endif
        end
    end

    // Bus outputs decoded from state; memory address/data are zero when idle.
    always_comb begin
        bus.c_ready  = (cstate == C_ACK);
        bus.c_rdata  = c_rdata_q;
        bus.m_write  = (mstate == M_WRITE);
        bus.m_read   = (mstate == M_READ);
        bus.m_addr   = '0;
        bus.m_wdata  = '0;
        bus.wb_empty = empty;
        bus.wb_full  = full;
        if (mstate == M_WRITE) begin
            bus.m_addr  = head_addr;
            bus.m_wdata = head_data;
        end else if (mstate == M_READ) begin
            bus.m_addr = bus.c_addr;
        end
    end
endmodule

// File: tb/tb_mem_write_buffer.sv
// Directed bench for mem_write_buffer: a per-cycle vector table plus
// hand-written sequences for back-pressure, forwarding/read-after-write and
// reset in the middle of a transaction.
module tb_mem_write_buffer;
    localparam int unsigned AW = 28;
    localparam int unsigned DW = 128;
    localparam int unsigned NV = 18;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    mem_write_buffer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_write_buffer #(
        .DEPTH  (4),
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk          (clk),
        .proc_reset_n (rst_n),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          mrdy;
        logic [DW-1:0] mrdata;
        logic          e_crdy;
        logic          e_mw;
        logic          e_mr;
        logic [AW-1:0] e_maddr;
        logic [DW-1:0] e_mwdata;
        logic [DW-1:0] e_crdata;
        logic          e_empty;
        logic          e_full;
    } vec_t;

    vec_t tbl [NV];

    function automatic vec_t mk(input int unsigned wr, rd, addr, wdata, mrdy, mrdata,
                                input int unsigned crdy, mw, mr, maddr, mwdata, crdata, emp, ful);
        vec_t v;
        v.wr       = 1'(wr);
        v.rd       = 1'(rd);
        v.addr     = AW'(addr);
        v.wdata    = DW'(wdata);
        v.mrdy     = 1'(mrdy);
        v.mrdata   = DW'(mrdata);
        v.e_crdy   = 1'(crdy);
        v.e_mw     = 1'(mw);
        v.e_mr     = 1'(mr);
        v.e_maddr  = AW'(maddr);
        v.e_mwdata = DW'(mwdata);
        v.e_crdata = DW'(crdata);
        v.e_empty  = 1'(emp);
        v.e_full   = 1'(ful);
        return v;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cache write that must be acked on the next cycle; drops c_write during the ack.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input string name);
        bus.c_write = 1'b1;
        bus.c_addr  = a;
        bus.c_wdata = d;
        step();
        check(name, DW'(bus.c_ready), DW'(1));
        bus.c_write = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] exp_addr [4];
        int k;

        bus.c_read  = 1'b0;
        bus.c_write = 1'b0;
        bus.c_addr  = '0;
        bus.c_wdata = '0;
        bus.m_ready = 1'b0;
        bus.m_rdata = '0;

        //            wr rd addr  wd mr mrd   crdy mw mr maddr mwd  crd  emp ful
        tbl[0]  = mk(1, 0, 'h10, 1, 0, 0,    1, 0, 0, 0,    0,   0,    0, 0);
        tbl[1]  = mk(0, 0, 'h10, 1, 0, 0,    0, 1, 0, 'h10, 1,   0,    0, 0);
        tbl[2]  = mk(0, 0, 0,    0, 0, 0,    0, 1, 0, 'h10, 1,   0,    0, 0);
        tbl[3]  = mk(0, 0, 0,    0, 1, 0,    0, 0, 0, 0,    0,   0,    1, 0);
        tbl[4]  = mk(0, 0, 0,    0, 0, 0,    0, 0, 0, 0,    0,   0,    1, 0);
        tbl[5]  = mk(0, 1, 'h40, 0, 0, 0,    0, 0, 0, 0,    0,   0,    1, 0);
        tbl[6]  = mk(0, 1, 'h40, 0, 0, 0,    0, 0, 1, 'h40, 0,   0,    1, 0);
        tbl[7]  = mk(0, 1, 'h40, 0, 0, 0,    0, 0, 1, 'h40, 0,   0,    1, 0);
        tbl[8]  = mk(0, 1, 'h40, 0, 0, 0,    0, 0, 1, 'h40, 0,   0,    1, 0);
        tbl[9]  = mk(0, 1, 'h40, 0, 1, 'hAB, 1, 0, 0, 0,    0,   'hAB, 1, 0);
        tbl[10] = mk(0, 0, 0,    0, 0, 0,    0, 0, 0, 0,    0,   'hAB, 1, 0);
        tbl[11] = mk(1, 0, 'h1, 'h11, 0, 0,  1, 0, 0, 0,    0,   'hAB, 0, 0);
        tbl[12] = mk(0, 0, 0,    0, 0, 0,    0, 1, 0, 'h1,  'h11, 'hAB, 0, 0);
        tbl[13] = mk(1, 0, 'h20, 5, 0, 0,    1, 1, 0, 'h1,  'h11, 'hAB, 0, 0);
        tbl[14] = mk(0, 0, 0,    0, 0, 0,    0, 1, 0, 'h1,  'h11, 'hAB, 0, 0);
        tbl[15] = mk(1, 0, 'h20, 6, 0, 0,    1, 1, 0, 'h1,  'h11, 'hAB, 0, 0);
        tbl[16] = mk(0, 0, 0,    0, 1, 0,    0, 1, 0, 'h20, 6,   'hAB, 0, 0);
        tbl[17] = mk(0, 0, 0,    0, 1, 0,    0, 0, 0, 0,    0,   'hAB, 1, 0);

        // Reset values while reset is held.
        #12;
        check("rst.c_ready",  DW'(bus.c_ready),  DW'(0));
        check("rst.c_rdata",  bus.c_rdata,       DW'(0));
        check("rst.m_read",   DW'(bus.m_read),   DW'(0));
        check("rst.m_write",  DW'(bus.m_write),  DW'(0));
        check("rst.m_addr",   DW'(bus.m_addr),   DW'(0));
        check("rst.m_wdata",  bus.m_wdata,       DW'(0));
        check("rst.wb_empty", DW'(bus.wb_empty), DW'(1));
        check("rst.wb_full",  DW'(bus.wb_full),  DW'(0));
        rst_n = 1'b1;
        step();

        // Single write, empty-buffer read, coalescing behind an in-flight head.
        for (int i = 0; i < int'(NV); i++) begin
            bus.c_write = tbl[i].wr;
            bus.c_read  = tbl[i].rd;
            bus.c_addr  = tbl[i].addr;
            bus.c_wdata = tbl[i].wdata;
            bus.m_ready = tbl[i].mrdy;
            bus.m_rdata = tbl[i].mrdata;
            step();
            check($sformatf("v%0d.c_ready", i),  DW'(bus.c_ready),  DW'(tbl[i].e_crdy));
            check($sformatf("v%0d.m_write", i),  DW'(bus.m_write),  DW'(tbl[i].e_mw));
            check($sformatf("v%0d.m_read", i),   DW'(bus.m_read),   DW'(tbl[i].e_mr));
            check($sformatf("v%0d.m_addr", i),   DW'(bus.m_addr),   DW'(tbl[i].e_maddr));
            check($sformatf("v%0d.m_wdata", i),  bus.m_wdata,       tbl[i].e_mwdata);
            check($sformatf("v%0d.c_rdata", i),  bus.c_rdata,       tbl[i].e_crdata);
            check($sformatf("v%0d.wb_empty", i), DW'(bus.wb_empty), DW'(tbl[i].e_empty));
            check($sformatf("v%0d.wb_full", i),  DW'(bus.wb_full),  DW'(tbl[i].e_full));
        end
        bus.c_read  = 1'b0;
        bus.c_write = 1'b0;
        bus.m_ready = 1'b0;
        bus.m_rdata = '0;
        step();

        // Fill with memory stalled, back-pressure a fifth write, then drain in order.
        for (int i = 1; i <= 4; i++) begin
            do_write(AW'(i), DW'(i + 'h100), $sformatf("fill%0d.ack", i));
        end
        check("fill.wb_full", DW'(bus.wb_full), DW'(1));
        bus.c_write = 1'b1;
        bus.c_addr  = AW'(5);
        bus.c_wdata = DW'('h105);
        step();
        step();
        step();
        check("full.no_ack",     DW'(bus.c_ready), DW'(0));
        check("full.head_addr",  DW'(bus.m_addr),  DW'(1));
        check("full.head_data",  bus.m_wdata,      DW'('h101));
        bus.m_ready = 1'b1;
        step();
        bus.m_ready = 1'b0;
        check("pop.no_ack_yet",  DW'(bus.c_ready), DW'(0));
        check("pop.wb_full",     DW'(bus.wb_full), DW'(0));
        step();
        check("pop.ack",         DW'(bus.c_ready), DW'(1));
        check("pop.refull",      DW'(bus.wb_full), DW'(1));
        bus.c_write = 1'b0;
        exp_addr[0] = AW'(2);
        exp_addr[1] = AW'(3);
        exp_addr[2] = AW'(4);
        exp_addr[3] = AW'(5);
        k = 0;
        for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
            if (bus.m_write) begin
                check($sformatf("drain%0d.m_addr", k), DW'(bus.m_addr), DW'(exp_addr[k]));
                k++;
                bus.m_ready = 1'b1;
            end else begin
                bus.m_ready = 1'b0;
            end
            step();
        end
        bus.m_ready = 1'b0;
        check("drain.count",    DW'(k),            DW'(4));
        check("drain.wb_empty", DW'(bus.wb_empty), DW'(1));
        step();

        // Read after write to the same line.
        do_write(AW'('h30), DW'(7), "raw.ack");
        bus.c_read = 1'b1;
        bus.c_addr = AW'('h30);
        step();
`ifdef WBUF_FWD_EN
        check("fwd.c_ready", DW'(bus.c_ready), DW'(1));
        check("fwd.c_rdata", bus.c_rdata,      DW'(7));
        check("fwd.m_read",  DW'(bus.m_read),  DW'(0));
        bus.c_read  = 1'b0;
        bus.m_ready = 1'b1;
        step();
        bus.m_ready = 1'b0;
        check("fwd.drained", DW'(bus.wb_empty), DW'(1));
        step();
        check("fwd.no_read", DW'(bus.m_read), DW'(0));
`else
        check("raw.wait_ack",   DW'(bus.c_ready), DW'(0));
        check("raw.no_read0",   DW'(bus.m_read),  DW'(0));
        step();
        check("raw.no_read1",   DW'(bus.m_read),  DW'(0));
        check("raw.m_write",    DW'(bus.m_write), DW'(1));
        bus.m_ready = 1'b1;
        step();
        bus.m_ready = 1'b0;
        check("raw.no_read2",   DW'(bus.m_read),  DW'(0));
        step();
        check("raw.m_read",     DW'(bus.m_read),  DW'(1));
        check("raw.m_addr",     DW'(bus.m_addr),  DW'('h30));
        bus.m_ready = 1'b1;
        bus.m_rdata = DW'('h5A5A);
        step();
        bus.m_ready = 1'b0;
        bus.c_read  = 1'b0;
        check("raw.c_ready",    DW'(bus.c_ready), DW'(1));
        check("raw.c_rdata",    bus.c_rdata,      DW'('h5A5A));
        check("raw.read_done",  DW'(bus.m_read),  DW'(0));
        step();
`endif

        // Reset asserted with a drain in flight and an ack on the bus.
        do_write(AW'('h77), DW'(9), "rmid.ack0");
        bus.c_write = 1'b1;
        bus.c_addr  = AW'('h78);
        bus.c_wdata = DW'(10);
        step();
        check("rmid.c_ready_pre", DW'(bus.c_ready), DW'(1));
        check("rmid.m_write_pre", DW'(bus.m_write), DW'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("rmid.m_write",  DW'(bus.m_write),  DW'(0));
        check("rmid.m_addr",   DW'(bus.m_addr),   DW'(0));
        check("rmid.m_wdata",  bus.m_wdata,       DW'(0));
        check("rmid.c_ready",  DW'(bus.c_ready),  DW'(0));
        check("rmid.wb_empty", DW'(bus.wb_empty), DW'(1));
        check("rmid.c_rdata",  bus.c_rdata,       DW'(0));
        bus.c_write = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("rmid.idle_empty", DW'(bus.wb_empty), DW'(1));
        check("rmid.idle_mw",    DW'(bus.m_write),  DW'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
